prog_loader: RTL and testbench
==============================

# prog_loader

Program-memory writer for the processor's instruction memory, the write-side counterpart of the program counter's read addressing. It consumes a byte stream from the UART receiver, assembles 16-bit instruction words, and writes them to consecutive program-memory addresses starting at 0. It raises `done` when the program is in memory; the top level gates the program counter's `enable` with `done`.

## Interface
- `ADDR_W`, default 11: program-memory address width; must match the program counter's `addr` width.
- `DATA_W`, default 16: instruction width. The block is fixed at two bytes per word.
- `DEPTH`, default 2048: maximum number of words; equals 2^ADDR_W.

- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `rx_data`  in  8: received byte.
- `rx_valid`  in  1: one-cycle strobe; `rx_data` is valid in that cycle.
- `load`  in  1: one-cycle pulse that restarts the load sequence.
- `wr_en`  out  1: program-memory write strobe, one cycle per word.
- `wr_addr`  out  ADDR_W: write address.
- `wr_data`  out  DATA_W: write data.
- `done`  out  1: program is fully loaded (level).
- `busy`  out  1: a load is in progress (at least one byte accepted, not yet done).
- `overflow`  out  1: sticky flag; the header length was clamped.

## Operation
- Stream format:
  - Header: length low byte, then length high byte.
  - Body: N words, each sent low byte first, then high byte.
- Length rules:
  - N = {hi, lo} as a 16-bit value.
  - N > DEPTH: clamp to DEPTH and set `overflow`.
  - N = 0: go to DONE with no writes.
- FSM states: LEN_LO, LEN_HI, W_LO, W_HI, DONE. Reset state is LEN_LO.
- Transitions (each occurs on `rx_valid`):
  - LEN_LO → LEN_HI: latch the low length byte.
  - LEN_HI → W_LO when N ≠ 0; LEN_HI → DONE when N = 0.
  - W_LO → W_HI: latch the low data byte.
  - W_HI → W_LO, or W_HI → DONE when this is word N: issue the write.
- DONE: `rx_valid` is ignored. Only `load` or `reset` leaves DONE.
- `load` in any state:
  - Next state is LEN_LO.
  - Word counter and `wr_addr` return to 0.
  - `done`, `busy` and `overflow` clear.
  - `load` has priority over a simultaneous `rx_valid`; that byte is discarded.
- Address and count rules:
  - `wr_addr` is 0 for the first word and increments by 1 after each write.
  - The internal word counter is ADDR_W+1 bits wide, so it can represent DEPTH.
  - Clamping guarantees `wr_addr` never wraps past DEPTH-1.
- Memory content is not cleared by `reset` or `load`. A partial load leaves the already-written words in place, and `done` stays 0.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `busy`=0, `overflow`=0.
- All outputs are registered.
- Write timing:
  - `wr_en` is high for exactly one cycle, the cycle after the edge that accepts the high data byte.
  - `wr_addr` and `wr_data` are stable for that whole cycle.
- The next byte may be accepted in the same cycle that `wr_en` is high. Back-to-back `rx_valid` on every cycle is supported with no byte loss and no stall.
- `done` rises on the same edge that raises the final `wr_en`.
- For N = 0, `done` rises on the edge after the high length byte is accepted.
- `busy` rises on the edge after the first header byte is accepted and falls on the edge where `done` rises.
- `overflow` is updated on the edge that accepts the high length byte.
- Asserting `reset` mid-operation immediately forces every output to its reset value. Operation restarts in LEN_LO on the first edge after `reset` deasserts.

## Test plan
- Three-word load:
  - Stimulus: bytes 03 00 34 12 78 56 BC 9A, sent back-to-back.
  - Required: writes (0, 0x1234), (1, 0x5678), (2, 0x9ABC); `done`=1 on the third `wr_en` edge; `busy` falls on that same edge; `overflow`=0.
- Zero length:
  - Stimulus: 00 00.
  - Required: no `wr_en`; `done`=1 one cycle after the second byte.
- Clamp:
  - Stimulus: header 00 09 (N=0x0900), followed by 2048 words.
  - Required: `overflow`=1; exactly 2048 writes; last `wr_addr`=0x7FF; `done`=1; extra trailing bytes produce no writes.
- Gapped stream:
  - Stimulus: the same stream as the three-word load, with random 0–20 idle cycles between bytes.
  - Required: identical write sequence and `done` timing relative to the last byte.
- Reset mid-load:
  - Stimulus: assert `reset` after 03 00 34 12 78; release it; send a fresh 01 00 EF BE.
  - Required: all outputs are 0 during reset; then one write (0, 0xBEEF) and `done`=1.
- Reload:
  - Stimulus: in DONE, pulse `load` in the same cycle as `rx_valid`=1 with byte 0x55, then send 02 00 11 11 22 22.
  - Required: byte 0x55 is discarded; `done` clears; writes (0, 0x1111), (1, 0x2222); `done`=1.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
`timescale 1ns/1ps
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              load;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              done;
  logic              busy;
  logic              overflow;

  // Byte source and load control side.
  modport master (
    output rx_data, rx_valid, load,
    input  wr_en, wr_addr, wr_data, done, busy, overflow
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_valid, load,
    output wr_en, wr_addr, wr_data, done, busy, overflow
  );
endinterface

// File: rtl/prog_loader.sv
// Assembles little-endian 16-bit words from a UART byte stream (length header first)
// and writes them to consecutive program-memory addresses starting at 0.
`timescale 1ns/1ps
module prog_loader #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [2:0] {LEN_LO, LEN_HI, W_LO, W_HI, DONE} state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [7:0]        lo_q, lo_d;
  logic [CW-1:0]     n_q, n_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       len16_c;
  logic [CW-1:0]     cnt_inc_c;

  // Next-state and output decode; load outranks any byte in the same cycle.
  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    lo_d      = lo_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    len16_c   = {bus.rx_data, len_lo_q};
    cnt_inc_c = cnt_q + CW'(1);

    if (bus.load) begin
      state_d   = LEN_LO;
      cnt_d     = '0;
      wr_addr_d = '0;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      ovf_d     = 1'b0;
    end else if (bus.rx_valid) begin
      unique case (state_q)
        LEN_LO: begin
          len_lo_d = bus.rx_data;
          busy_d   = 1'b1;
          state_d  = LEN_HI;
        end
        LEN_HI: begin
          ovf_d = ({1'b0, len16_c} > DEPTH_L);
          if (len16_c == 16'd0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            // Clamp so the address counter can never run past DEPTH-1.
            n_d     = ({1'b0, len16_c} > DEPTH_L) ? CW'(DEPTH) : CW'(len16_c);
            state_d = W_LO;
          end
        end
        W_LO: begin
          lo_d    = bus.rx_data;
          state_d = W_HI;
        end
        W_HI: begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = DATA_W'({bus.rx_data, lo_q});
          cnt_d     = cnt_inc_c;
          if (cnt_inc_c == n_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = W_LO;
          end
        end
        DONE: ;
        default: state_d = LEN_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LEN_LO;
      len_lo_q  <= '0;
      lo_q      <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      lo_q      <= lo_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as words are sent.
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2048;

  logic clk = 1'b0;
  logic reset;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned wr_cnt   = 0;
  logic [15:0] exp_addr;
  logic [31:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("wr_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(e[31:16]));
        check("wr_data", 32'(bus.wr_data), 32'(e[15:0]));
      end
    end
  end

  // All driving happens 1ns after a rising edge.
  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    idle(gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input int unsigned gap);
    sb.push_back({exp_addr, d});
    exp_addr = exp_addr + 16'd1;
    send_byte(d[7:0], gap);
    send_byte(d[15:8], gap);
  endtask

  task automatic pulse_load();
    bus.load = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    exp_addr = '0;
    wr_cnt   = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},   32'(bus.wr_en),    32'd0);
    check({tag, "_wr_addr"}, 32'(bus.wr_addr),  32'd0);
    check({tag, "_wr_data"}, 32'(bus.wr_data),  32'd0);
    check({tag, "_done"},    32'(bus.done),     32'd0);
    check({tag, "_busy"},    32'(bus.busy),     32'd0);
    check({tag, "_ovf"},     32'(bus.overflow), 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.load     = 1'b0;
    exp_addr     = '0;
    idle(3);
    check_all_zero("rst");
    reset = 1'b1;
    idle(1);

    // Three-word load, back-to-back bytes.
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    send_word(16'h1234, 0);
    send_word(16'h5678, 0);
    send_word(16'h9ABC, 0);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_last_wr_en", 32'(bus.wr_en), 32'd1);
    check("t1_busy_fall", 32'(bus.busy), 32'd0);
    check("t1_ovf", 32'(bus.overflow), 32'd0);
    idle(3);
    check("t1_wr_cnt", wr_cnt, 32'd3);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Zero length.
    pulse_load();
    check("t2_done_clr", 32'(bus.done), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_busy", 32'(bus.busy), 32'd0);
    idle(3);
    check("t2_wr_cnt", wr_cnt, 32'd0);

    // Gapped stream.
    pulse_load();
    send_byte(8'h03, $urandom_range(20, 0));
    send_byte(8'h00, $urandom_range(20, 0));
    send_word(16'h1234, $urandom_range(20, 0));
    send_word(16'h5678, $urandom_range(20, 0));
    sb.push_back({exp_addr, 16'h9ABC});
    exp_addr = exp_addr + 16'd1;
    send_byte(8'hBC, $urandom_range(20, 0));
    idle($urandom_range(20, 0));
    check("t3_done_early", 32'(bus.done), 32'd0);
    send_byte(8'h9A, 0);
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_last_wr_en", 32'(bus.wr_en), 32'd1);
    idle(3);
    check("t3_wr_cnt", wr_cnt, 32'd3);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-load.
    pulse_load();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_word(16'h1234, 0);
    send_byte(8'h78, 0);
    reset = 1'b0;
    #1;
    check_all_zero("t4_rst");
    idle(2);
    reset = 1'b1;
    idle(1);
    exp_addr = '0;
    wr_cnt   = 0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(16'hBEEF, 0);
    check("t4_done", 32'(bus.done), 32'd1);
    idle(3);
    check("t4_wr_cnt", wr_cnt, 32'd1);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Reload: load collides with a byte, which must be dropped.
    bus.rx_data  = 8'h55;
    bus.rx_valid = 1'b1;
    pulse_load();
    bus.rx_valid = 1'b0;
    check("t5_done_clr", 32'(bus.done), 32'd0);
    check("t5_busy_clr", 32'(bus.busy), 32'd0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    check("t5_done", 32'(bus.done), 32'd1);
    idle(3);
    check("t5_wr_cnt", wr_cnt, 32'd2);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Clamp: header 0x0900 words, only DEPTH accepted.
    pulse_load();
    send_byte(8'h00, 0);
    send_byte(8'h09, 0);
    check("t6_ovf", 32'(bus.overflow), 32'd1);
    for (int k = 0; k < int'(DEPTH); k++) begin
      send_word(16'(k * 7 + 3), 0);
    end
    check("t6_done", 32'(bus.done), 32'd1);
    check("t6_last_addr", 32'(bus.wr_addr), 32'h7FF);
    for (int k = 0; k < 4; k++) begin
      send_byte(8'(k + 8'hA0), 0);
    end
    idle(3);
    check("t6_wr_cnt", wr_cnt, 32'(DEPTH));
    check("t6_done_hold", 32'(bus.done), 32'd1);
    check("t6_ovf_hold", 32'(bus.overflow), 32'd1);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    pulse_load();
    check("t6_ovf_clr", 32'(bus.overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
